// File: rtl/led_pkg.sv
// Shared register map and mode encoding for the LED output peripheral.
package led_pkg;

  localparam logic [1:0] ADDR_DATA  = 2'd0;
  localparam logic [1:0] ADDR_MODE  = 2'd1;
  localparam logic [1:0] ADDR_DUTY  = 2'd2;
  localparam logic [1:0] ADDR_BLINK = 2'd3;

  // Code 3 is reserved and is displayed like STATIC.
  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_PWM    = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

endpackage

// File: rtl/led_pwm_gen.sv
// Free-running PWM generator: owns the PWM counter and the duty edge rules
// (all-ones duty is fully on, zero duty is fully off).
module led_pwm_gen #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                restart,
  input  logic [PWM_BITS-1:0] duty,
  output logic                pwm_on
);

  logic [PWM_BITS-1:0] pwm_cnt;

  // Counter wraps naturally from all-ones to zero; restart re-aligns the period.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
    end else if (restart) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end
  end

  // Plain compare would leave one dark clock per period at all-ones duty.
  assign pwm_on = (duty == '1) || (pwm_cnt < duty);

endmodule

// File: rtl/led_pwm_ctrl.sv
// Memory-mapped LED peripheral: register file, blink timer, PWM dimming
// and a registered LED output selected by MODE.
import led_pkg::*;

module led_pwm_ctrl #(
  parameter int NUM_LEDS = 24,
  parameter int PWM_BITS = 8,
  parameter int BLINK_W  = 26
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [1:0]          addr,
  input  logic [31:0]         wdata,
  output logic [31:0]         rdata,
  output logic [NUM_LEDS-1:0] led
);

  logic [NUM_LEDS-1:0] data_q;
  mode_e               mode_q;
  logic [PWM_BITS-1:0] duty_q;
  logic [BLINK_W-1:0]  blink_hp_q;
  logic [BLINK_W-1:0]  blink_cnt;
  logic [BLINK_W-1:0]  blink_last;
  logic                blink_ph;
  logic                pwm_on;
  logic                restart;
  logic [NUM_LEDS-1:0] led_next;
  logic                unused_wdata_bits;

  // Upper write-data bits beyond the widest register are intentionally ignored.
  assign unused_wdata_bits = ^wdata;

  // A MODE write restarts both blink and PWM phases.
  assign restart = wr_en && (addr == ADDR_MODE);

  // Register file: one truncated write per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q     <= '0;
      mode_q     <= MODE_STATIC;
      duty_q     <= '1;
      blink_hp_q <= '0;
    end else if (wr_en) begin
      case (addr)
        ADDR_DATA:  data_q     <= wdata[NUM_LEDS-1:0];
        ADDR_MODE:  mode_q     <= mode_e'(wdata[1:0]);
        ADDR_DUTY:  duty_q     <= wdata[PWM_BITS-1:0];
        ADDR_BLINK: blink_hp_q <= wdata[BLINK_W-1:0];
        default:    ;
      endcase
    end
  end

  // Last count of a half-period; HP of 0 behaves as 1 (toggle every clock).
  assign blink_last = (blink_hp_q == '0) ? '0 : blink_hp_q - BLINK_W'(1);

  // Blink timer: ">=" makes a shrunk HP wrap on the next clock instead of
  // running through the whole counter range.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      blink_ph  <= 1'b1;
    end else if (restart) begin
      blink_cnt <= '0;
      blink_ph  <= 1'b1;
    end else if (blink_cnt >= blink_last) begin
      blink_cnt <= '0;
      blink_ph  <= ~blink_ph;
    end else begin
      blink_cnt <= blink_cnt + BLINK_W'(1);
    end
  end

  led_pwm_gen #(
    .PWM_BITS (PWM_BITS)
  ) u_pwm (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart),
    .duty    (duty_q),
    .pwm_on  (pwm_on)
  );

  // Mode mux: gate the pattern with the selected modulation.
  // NOTE: assigning a default first keeps this block free of inferred latches.
  always_comb begin
    led_next = data_q;
    case (mode_q)
      MODE_BLINK: led_next = data_q & {NUM_LEDS{blink_ph}};
      MODE_PWM:   led_next = data_q & {NUM_LEDS{pwm_on}};
      default:    led_next = data_q;
    endcase
  end

  // Registered LED drive, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led <= '0;
    end else begin
      led <= led_next;
    end
  end

  // Side-effect-free readback of the software-visible registers.
  always_comb begin
    rdata = '0;
    case (addr)
      ADDR_DATA:  rdata[NUM_LEDS-1:0] = data_q;
      ADDR_MODE:  rdata[1:0]          = mode_q;
      ADDR_DUTY:  rdata[PWM_BITS-1:0] = duty_q;
      ADDR_BLINK: rdata[BLINK_W-1:0]  = blink_hp_q;
      default:    rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Directed bench for led_pwm_ctrl: register table, then blink, PWM,
// phase-restart, truncation and async-reset sequences.
module tb_led_pwm_ctrl;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [23:0] led;

  int n_vec;
  int n_err;

  typedef struct {
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [23:0] exp_led;
  } vec_t;

  vec_t vecs [8];

  led_pwm_ctrl #(
    .NUM_LEDS (24),
    .PWM_BITS (8),
    .BLINK_W  (26)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wr_en (wr_en),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .led   (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Called at a negedge; the write lands on the following posedge and the
  // task returns at the negedge after it.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    wr_en = 1'b1;
    addr  = a;
    wdata = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  initial begin
    int cnt;
    logic [23:0] prev;
    logic [23:0] exp_led;

    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    wr_en = 1'b0;
    addr  = 2'd0;
    wdata = 32'h0;

    vecs[0] = '{2'd0, 32'h00A5_5A5A, 32'h00A5_5A5A, 24'hA55A5A};
    vecs[1] = '{2'd0, 32'hFF12_3456, 32'h0012_3456, 24'h123456};
    vecs[2] = '{2'd1, 32'h0000_0003, 32'h0000_0003, 24'h123456};
    vecs[3] = '{2'd1, 32'hFFFF_FFFC, 32'h0000_0000, 24'h123456};
    vecs[4] = '{2'd2, 32'h0000_0123, 32'h0000_0023, 24'h123456};
    vecs[5] = '{2'd3, 32'hFFFF_FFFF, 32'h03FF_FFFF, 24'h123456};
    vecs[6] = '{2'd0, 32'h0000_0000, 32'h0000_0000, 24'h000000};
    vecs[7] = '{2'd0, 32'h00FF_FFFF, 32'h00FF_FFFF, 24'hFFFFFF};

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_led", led, 24'h0);
    addr = 2'd2;
    #1 check("reset_duty", rdata, 32'h0000_00FF);
    rst_n = 1'b1;
    @(negedge clk);

    // Register table in static mode
    for (int i = 0; i < 8; i++) begin
      wr(vecs[i].addr, vecs[i].wdata);
      @(negedge clk);
      check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d_led", i), led, vecs[i].exp_led);
    end

    // Async reset mid-run with all LEDs lit
    #2 rst_n = 1'b0;
    #1 check("async_rst_led", led, 24'h0);
    addr = 2'd1;
    #1 check("async_rst_mode", rdata, 32'h0);
    addr = 2'd0;
    #1 check("async_rst_data", rdata, 32'h0);
    addr = 2'd3;
    #1 check("async_rst_hp", rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Blink HP=4: on 4, off 4, on 4
    wr(2'd0, 32'h00FF_FFFF);
    wr(2'd3, 32'd4);
    wr(2'd1, 32'd1);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      exp_led = (((k - 1) / 4) % 2 == 0) ? 24'hFFFFFF : 24'h0;
      check($sformatf("blink4_k%0d", k), led, exp_led);
    end

    // Blink HP=0: toggle every clock
    wr(2'd3, 32'd0);
    @(negedge clk);
    prev = led;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("blink0_k%0d", k), led, prev ^ 24'hFFFFFF);
      prev = led;
    end

    // Phase restart from the middle of an off phase
    wr(2'd3, 32'd4);
    wr(2'd1, 32'd1);
    repeat (6) @(negedge clk);
    check("restart_pre_off", led, 24'h0);
    wr(2'd1, 32'd1);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      exp_led = (k <= 4) ? 24'hFFFFFF : 24'h0;
      check($sformatf("restart_k%0d", k), led, exp_led);
    end

    // PWM duty 64: exactly the first 64 clocks of each 256 are lit
    wr(2'd0, 32'h0000_0001);
    wr(2'd2, 32'd64);
    wr(2'd1, 32'd2);
    cnt = 0;
    for (int k = 1; k <= 256; k++) begin
      @(negedge clk);
      exp_led = (k <= 64) ? 24'h000001 : 24'h0;
      if (led[0]) cnt++;
      check($sformatf("pwm64_k%0d", k), led, exp_led);
    end
    check("pwm64_count", cnt, 64);

    // DUTY=0: never lit
    wr(2'd2, 32'd0);
    @(negedge clk);
    cnt = 0;
    for (int k = 0; k < 256; k++) begin
      @(negedge clk);
      if (led[0]) cnt++;
    end
    check("pwm0_count", cnt, 0);

    // DUTY=255: always lit
    wr(2'd2, 32'd255);
    @(negedge clk);
    cnt = 0;
    for (int k = 0; k < 256; k++) begin
      @(negedge clk);
      if (led[0]) cnt++;
    end
    check("pwm255_count", cnt, 256);

    // Truncation and read-during-write
    wr(2'd1, 32'hFFFF_FFFE);
    addr = 2'd1;
    #1 check("trunc_mode", rdata, 32'h2);
    wr_en = 1'b1;
    addr  = 2'd2;
    wdata = 32'h0000_0123;
    #1 check("rdw_old_duty", rdata, 32'h0000_00FF);
    @(negedge clk);
    wr_en = 1'b0;
    #1 check("trunc_duty", rdata, 32'h0000_0023);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
